// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the 7-segment time-multiplexing scheduler.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

endpackage

// File: rtl/seg_display_sched_rr_picker.sv
// Round-robin requester search starting just after last_idx and wrapping back to it;
// optionally lets requester 0 win outright.
module rr_picker
  import seg_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter bit PRIO0 = 1'b1,
  parameter int IW    = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_idx,
  output logic            found,
  output logic [IW-1:0]   idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Walk from the farthest candidate to the nearest so the nearest active one wins.
  always_comb begin
    found    = |req;
    idx      = last_idx;
    cand     = 0;
    cand_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = int'(last_idx) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) idx = cand_idx;
    end
    if (PRIO0 && req[0]) idx = '0;
  end

endmodule

// File: rtl/seg_display_sched.sv
// Shares one 7-segment drive between NREQ pattern sources: round-robin grants held for a
// tick-based dwell, with forced blanking between owners to avoid ghosting.
//
// state | meaning
// IDLE  | no owner, outputs blank, waiting for en and a request
// BLANK | ownership changing, outputs blank for BLANK_TICKS ticks before next_idx shows
// SHOW  | last_idx owns the display until dwell expires, it drops, or req[0] preempts
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DWELL_W     = 8,
  parameter int BLANK_TICKS = 2,
  parameter bit PRIO0       = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tick,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   seg_bus,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [7:0]          seg_out,
  output logic [NREQ-1:0]     grant,
  output logic                switch_pulse
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (BLANK_TICKS < 2) ? 1 : $clog2(BLANK_TICKS + 1);

  state_e             state, state_n;
  logic [IW-1:0]      next_idx, next_idx_n, last_idx, last_idx_n, show_idx, pick_idx;
  logic [BW-1:0]      blank_cnt, blank_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_n, dwell_ld;
  logic               via_idle, via_idle_n, pulse_n, pick_found, handoff, enter_show;
  logic [7:0]         seg_d;
  logic [NREQ-1:0]    grant_d;

  rr_picker #(.NREQ(NREQ), .PRIO0(PRIO0), .IW(IW)) u_picker (
    .req      (req),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      next_idx     <= '0;
      last_idx     <= IW'(NREQ - 1);
      blank_cnt    <= '0;
      dwell_cnt    <= '0;
      via_idle     <= 1'b1;
      seg_out      <= SEG_BLANK;
      grant        <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      next_idx     <= next_idx_n;
      last_idx     <= last_idx_n;
      blank_cnt    <= blank_n;
      dwell_cnt    <= dwell_n;
      via_idle     <= via_idle_n;
      seg_out      <= seg_d;
      grant        <= grant_d;
      switch_pulse <= pulse_n;
    end
  end

  // handoff: move ownership to pick_idx (through BLANK unless blanking is disabled).
  always_comb begin
    state_n    = state;
    next_idx_n = next_idx;
    last_idx_n = last_idx;
    blank_n    = blank_cnt;
    dwell_n    = dwell_cnt;
    via_idle_n = via_idle;
    pulse_n    = 1'b0;
    handoff    = 1'b0;
    enter_show = 1'b0;
    show_idx   = next_idx;
    if (!en) begin
      state_n    = IDLE;
      via_idle_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          via_idle_n = 1'b1;
          handoff    = pick_found;
        end
        BLANK: begin
          if (!req[next_idx]) begin
            if (pick_found) next_idx_n = pick_idx;
            else            state_n    = IDLE;
          end else if (tick) begin
            if (blank_cnt <= BW'(1)) enter_show = 1'b1;
            else                     blank_n    = blank_cnt - BW'(1);
          end
        end
        SHOW: begin
          if (PRIO0 && req[0] && last_idx != '0) begin
            handoff = 1'b1;
          end else if (!req[last_idx]) begin
            if (pick_found) handoff = 1'b1;
            else            state_n = IDLE;
          end else if (tick) begin
            if (dwell_cnt == DWELL_W'(1)) begin
              if (pick_idx != last_idx) handoff = 1'b1;
              else                      dwell_n = dwell_ld;
            end else begin
              dwell_n = dwell_cnt - DWELL_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (handoff) begin
      next_idx_n = pick_idx;
      if (BLANK_TICKS == 0) begin
        enter_show = 1'b1;
        show_idx   = pick_idx;
      end else begin
        state_n = BLANK;
        blank_n = BW'(BLANK_TICKS);
      end
    end
    if (enter_show) begin
      state_n    = SHOW;
      last_idx_n = show_idx;
      dwell_n    = dwell_ld;
      pulse_n    = (show_idx != last_idx) || via_idle || (state == IDLE);
      via_idle_n = 1'b0;
    end
  end

  // Outputs follow the next state so grant and seg_out line up with the SHOW cycles.
  always_comb begin
    grant_d = '0;
    seg_d   = SEG_BLANK;
    if (state_n == SHOW) begin
      grant_d = NREQ'(1) << last_idx_n;
      for (int i = 0; i < NREQ; i++) begin
        if (last_idx_n == IW'(i)) seg_d = seg_bus[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched: scoreboard of expected grants checked on every
// switch_pulse, plus directed checks of timing, preemption, enable and reset behaviour.
module tb_seg_display_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  req_b = 4'b0000;
  logic [31:0] seg_bus;
  logic [7:0]  dwell = 8'd3;
  logic [7:0]  dwell_b = 8'd0;
  logic [7:0]  seg_out, seg_out_b;
  logic [3:0]  grant, grant_b;
  logic        switch_pulse, switch_pulse_b;

  int tests = 0;
  int fails = 0;
  int ph = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] s;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  assign seg_bus = {8'h4F, 8'h5B, 8'h06, 8'h3F};

  seg_display_sched #(.NREQ(4), .DWELL_W(8), .BLANK_TICKS(2), .PRIO0(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .req(req), .seg_bus(seg_bus),
    .dwell(dwell), .seg_out(seg_out), .grant(grant), .switch_pulse(switch_pulse)
  );

  seg_display_sched #(.NREQ(4), .DWELL_W(8), .BLANK_TICKS(0), .PRIO0(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .req(req_b), .seg_bus(seg_bus),
    .dwell(dwell_b), .seg_out(seg_out_b), .grant(grant_b), .switch_pulse(switch_pulse_b)
  );

  function automatic logic [7:0] seg_of(logic [3:0] g);
    case (g)
      4'b0001: return 8'h3F;
      4'b0010: return 8'h06;
      4'b0100: return 8'h5B;
      4'b1000: return 8'h4F;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(logic [3:0] g);
    exp_q.push_back({g, seg_of(g)});
  endtask

  // Inputs change 1 time unit after the rising edge; tick is high one cycle in four.
  task automatic clk_step();
    @(posedge clk);
    #1;
    ph   = (ph == 3) ? 0 : ph + 1;
    tick = (ph == 0);
  endtask

  task automatic wait_grant(string tag, logic [3:0] g);
    int n;
    n = 0;
    while (grant !== g && n < 200) begin
      clk_step();
      n++;
    end
    check(tag, {28'd0, grant}, {28'd0, g});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (($onehot0(grant) && (grant != 4'b0000 || seg_out == 8'h00)) === 1'b1) else begin
        fails++;
        $error("FAIL invariant: observed grant %b seg_out %h", grant, seg_out);
      end
      if (switch_pulse) begin
        mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests++;
        assert ({grant, seg_out} === mon_e) else begin
          fails++;
          $error("FAIL scoreboard: observed grant %b seg %h expected grant %b seg %h",
                 grant, seg_out, mon_e.g, mon_e.s);
        end
      end
    end
  end

  initial begin
    int n, cnt, bad;
    logic [3:0] prev, exp_g;
    logic t;

    #1 rst_n = 1'b0;
    #2;
    check("reset grant", {28'd0, grant}, 32'd0);
    check("reset seg_out", {24'd0, seg_out}, 32'd0);
    check("reset switch_pulse", {31'd0, switch_pulse}, 32'd0);
    repeat (2) clk_step();
    rst_n = 1'b1;
    clk_step();

    // Basic round-robin between sources 1 and 3
    dwell = 8'd3;
    req   = 4'b1010;
    expect_grant(4'b0010);
    expect_grant(4'b1000);
    expect_grant(4'b0010);
    expect_grant(4'b1000);
    en = 1'b1;
    wait_grant("rr first owner", 4'b0010);
    check("rr first seg", {24'd0, seg_out}, 32'h06);
    n = 0; cnt = 0;
    while (grant === 4'b0010 && n < 100) begin
      if (tick) cnt++;
      clk_step();
      n++;
    end
    check("rr show ticks", cnt, 3);
    check("rr blank after show", {28'd0, grant}, 32'd0);
    n = 0; cnt = 0;
    while (grant === 4'b0000 && n < 100) begin
      if (tick) cnt++;
      clk_step();
      n++;
    end
    check("rr blank ticks", cnt, 2);
    check("rr second owner", {28'd0, grant}, 32'b1000);
    check("rr second seg", {24'd0, seg_out}, 32'h4F);
    wait_grant("rr third owner", 4'b0010);
    wait_grant("rr fourth owner", 4'b1000);
    en = 1'b0;
    clk_step();
    check("en low grant", {28'd0, grant}, 32'd0);
    check("en low seg_out", {24'd0, seg_out}, 32'd0);
    check("rr pulses consumed", exp_q.size(), 0);

    // Single requester holds the display across dwell reloads
    req = 4'b0100;
    expect_grant(4'b0100);
    en = 1'b1;
    wait_grant("single owner", 4'b0100);
    bad = 0;
    repeat (40) begin
      clk_step();
      if (grant !== 4'b0100 || seg_out !== 8'h5B) bad++;
    end
    check("single steady", bad, 0);

    // Owner drop: leave SHOW at once without waiting out dwell
    expect_grant(4'b0010);
    req = 4'b0110;
    wait_grant("drop setup owner", 4'b0010);
    expect_grant(4'b0100);
    req = 4'b0100;
    clk_step();
    check("drop blank next cycle", {28'd0, grant}, 32'd0);
    wait_grant("drop new owner", 4'b0100);

    // Preemption of owner 3 by requester 0
    expect_grant(4'b1000);
    req = 4'b1100;
    wait_grant("preempt setup owner", 4'b1000);
    expect_grant(4'b0001);
    req = 4'b1101;
    clk_step();
    check("preempt blank next cycle", {28'd0, grant}, 32'd0);
    n = 0; cnt = 0;
    while (grant === 4'b0000 && n < 100) begin
      if (tick) cnt++;
      clk_step();
      n++;
    end
    check("preempt blank ticks", cnt, 2);
    check("preempt owner", {28'd0, grant}, 32'b0001);

    // Async reset mid-SHOW on source 1; afterwards search restarts at index 0
    expect_grant(4'b0010);
    req = 4'b0110;
    wait_grant("reset setup owner", 4'b0010);
    clk_step();
    rst_n = 1'b0;
    #1;
    check("async reset grant", {28'd0, grant}, 32'd0);
    check("async reset seg_out", {24'd0, seg_out}, 32'd0);
    repeat (2) clk_step();
    rst_n = 1'b1;
    expect_grant(4'b0010);
    wait_grant("first owner after reset", 4'b0010);
    req = 4'b0000;
    clk_step();

    // dwell 0 with no blanking: owner flips on every tick
    req_b = 4'b0011;
    n = 0;
    while (grant_b === 4'b0000 && n < 50) begin
      clk_step();
      n++;
    end
    check("nb first owner", {28'd0, grant_b}, 32'b0001);
    bad = 0;
    repeat (24) begin
      prev = grant_b;
      t    = tick;
      clk_step();
      exp_g = t ? ((prev == 4'b0001) ? 4'b0010 : 4'b0001) : prev;
      if (grant_b !== exp_g || switch_pulse_b !== t || seg_out_b !== seg_of(exp_g)) bad++;
    end
    check("nb alternate every tick", bad, 0);

    clk_step();
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
